// File: rtl/wb_pkg.sv
// ============================================================================
//  wb_pkg : shared types, byte-select encodings and load-extend helper for
//           the multi-lane write-back stage.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package wb_pkg;

    localparam int WB_XLEN    = 32;
    localparam int WB_RADDR_W = 5;

    localparam logic [3:0] BSEL_B0 = 4'b0001;
    localparam logic [3:0] BSEL_B1 = 4'b0010;
    localparam logic [3:0] BSEL_B2 = 4'b0100;
    localparam logic [3:0] BSEL_B3 = 4'b1000;
    localparam logic [3:0] BSEL_H0 = 4'b0011;
    localparam logic [3:0] BSEL_H1 = 4'b1100;
    localparam logic [3:0] BSEL_W  = 4'b1111;

    typedef struct packed {
        logic [WB_XLEN-1:0]    pc;
        logic                  we;
        logic [WB_RADDR_W-1:0] waddr;
        logic [WB_XLEN-1:0]    wdata;
    } trace_entry_t;

    // Top bit flags data that came from a load, for load-use aware consumers.
    typedef struct packed {
        logic                  load;
        logic                  valid;
        logic                  wen;
        logic [WB_RADDR_W-1:0] waddr;
        logic [WB_XLEN-1:0]    wdata;
    } byp_lane_t;

    localparam int BYP_LANE_W = $bits(byp_lane_t);

    function automatic logic [WB_XLEN-1:0] wb_load_ext(
        input logic [3:0]         bsel,
        input logic [WB_XLEN-1:0] rdata,
        input logic               is_unsigned
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [WB_XLEN-1:0] res;
        b   = 8'h00;
        h   = 16'h0000;
        res = '0;
        case (bsel)
            BSEL_B0: b = rdata[7:0];
            BSEL_B1: b = rdata[15:8];
            BSEL_B2: b = rdata[23:16];
            BSEL_B3: b = rdata[31:24];
            BSEL_H0: h = rdata[15:0];
            BSEL_H1: h = rdata[31:16];
            default: ;
        endcase
        case (bsel)
            BSEL_B0, BSEL_B1, BSEL_B2, BSEL_B3:
                res = {{24{~is_unsigned & b[7]}}, b};
            BSEL_H0, BSEL_H1:
                res = {{16{~is_unsigned & h[15]}}, h};
            BSEL_W:
                res = rdata;
            default:
                res = '0;
        endcase
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/wb_trace_fifo.sv
// ============================================================================
//  wb_trace_fifo : multi-push / single-pop trace FIFO. Valid push lanes are
//                  packed in lane order; one entry drains every cycle.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module wb_trace_fifo
    import wb_pkg::*;
#(
    parameter int LANES = 2,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [LANES-1:0] push_vld,
    input  trace_entry_t     push_data [LANES],
    output trace_entry_t     head,
    output logic             head_vld,
    output logic [CW-1:0]    free_cnt
);

    trace_entry_t  mem [DEPTH];
    logic [CW-1:0] wr_ptr;
    logic [CW-1:0] rd_ptr;
    logic [CW-1:0] used;
    logic [CW-1:0] push_cnt;
    logic [CW-1:0] slot_ptr [LANES];
    logic          empty;
    logic          full;

    // Each valid lane lands after all lower valid lanes of the same push.
    always_comb begin
        push_cnt = '0;
        for (int i = 0; i < LANES; i++) begin
            slot_ptr[i] = wr_ptr + push_cnt;
            if (push_vld[i]) begin
                push_cnt = push_cnt + CW'(1);
            end
        end
    end

    assign used     = wr_ptr - rd_ptr;
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign free_cnt = full ? '0 : (CW'(DEPTH) - used);
    assign head_vld = ~empty;
    assign head     = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            wr_ptr <= wr_ptr + push_cnt;
            if (!empty) begin
                rd_ptr <= rd_ptr + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (push_vld[i]) begin
                mem[slot_ptr[i][AW-1:0]] <= push_data[i];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/wb_stage_mlane.sv
// ============================================================================
//  wb_stage_mlane : multi-lane write-back stage (load extend, same-register
//                   conflict kill, RF/bypass drive). Define WB_DEBUG_TRACE_EN
//                   to build the trace FIFO and its backpressure.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module wb_stage_mlane
    import wb_pkg::*;
#(
    parameter int LANES          = 2,
    parameter int XLEN           = WB_XLEN,
    parameter int RADDR_W        = WB_RADDR_W,
    parameter int DBG_FIFO_DEPTH = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              mem_to_wb_valid,
    output logic                              wb_allow_in,
    input  logic [LANES-1:0]                  lane_valid,
    input  logic [LANES*XLEN-1:0]             lane_pc,
    input  logic [LANES-1:0]                  lane_rf_wen,
    input  logic [LANES*RADDR_W-1:0]          lane_rf_waddr,
    input  logic [LANES-1:0]                  lane_sel_mem,
    input  logic [LANES*4-1:0]                lane_mem_bsel,
    input  logic [LANES-1:0]                  lane_mem_unsigned,
    input  logic [LANES*XLEN-1:0]             lane_mem_rdata,
    input  logic [LANES*XLEN-1:0]             lane_alu_result,
    output logic [LANES-1:0]                  rf_we,
    output logic [LANES*RADDR_W-1:0]          rf_waddr,
    output logic [LANES*XLEN-1:0]             rf_wdata,
    output logic [LANES*(3+RADDR_W+XLEN)-1:0] wb_to_by_bus,
    output logic [XLEN-1:0]                   debug_wb_pc,
    output logic [3:0]                        debug_wb_rf_wen,
    output logic [RADDR_W-1:0]                debug_wb_rf_wnum,
    output logic [XLEN-1:0]                   debug_wb_rf_wdata
);

    localparam int BYP_W = 3 + RADDR_W + XLEN;

    logic                     wb_valid;
    logic                     wb_ready_go;
    logic                     bundle_go;
    logic                     accept;
    logic [LANES-1:0]         b_valid;
    logic [LANES-1:0]         b_rf_wen;
    logic [LANES-1:0]         b_sel_mem;
    logic [LANES-1:0]         b_unsigned;
    logic [LANES*RADDR_W-1:0] b_waddr;
    logic [LANES*4-1:0]       b_bsel;
    logic [LANES*XLEN-1:0]    b_rdata;
    logic [LANES*XLEN-1:0]    b_alu;
    logic [RADDR_W-1:0]       lane_waddr [LANES];
    logic [LANES-1:0]         lane_wr;
    logic [LANES-1:0]         kill;

    assign wb_allow_in = ~wb_valid | wb_ready_go;
    assign accept      = mem_to_wb_valid & wb_allow_in;
    assign bundle_go   = wb_valid & wb_ready_go;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_valid   <= 1'b0;
            b_valid    <= '0;
            b_rf_wen   <= '0;
            b_sel_mem  <= '0;
            b_unsigned <= '0;
            b_waddr    <= '0;
            b_bsel     <= '0;
            b_rdata    <= '0;
            b_alu      <= '0;
        end else begin
            if (wb_allow_in) begin
                wb_valid <= mem_to_wb_valid;
            end
            if (accept) begin
                b_valid    <= lane_valid;
                b_rf_wen   <= lane_rf_wen;
                b_sel_mem  <= lane_sel_mem;
                b_unsigned <= lane_mem_unsigned;
                b_waddr    <= lane_rf_waddr;
                b_bsel     <= lane_mem_bsel;
                b_rdata    <= lane_mem_rdata;
                b_alu      <= lane_alu_result;
            end
        end
    end

    // A lower lane is dropped when any higher lane writes the same register.
    always_comb begin
        kill = '0;
        for (int i = 0; i < LANES; i++) begin
            for (int j = i + 1; j < LANES; j++) begin
                if (lane_wr[j] && (lane_waddr[j] == lane_waddr[i])) begin
                    kill[i] = 1'b1;
                end
            end
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [XLEN-1:0] data;
        byp_lane_t       byp;

        assign lane_waddr[i] = b_waddr[i*RADDR_W +: RADDR_W];
        assign lane_wr[i]    = b_valid[i] & b_rf_wen[i];
        assign data          = b_sel_mem[i]
                             ? wb_load_ext(b_bsel[i*4 +: 4], b_rdata[i*XLEN +: XLEN], b_unsigned[i])
                             : b_alu[i*XLEN +: XLEN];

        assign rf_waddr[i*RADDR_W +: RADDR_W] = lane_waddr[i];
        assign rf_wdata[i*XLEN +: XLEN]       = (lane_waddr[i] == '0) ? '0 : data;
        assign rf_we[i] = bundle_go & lane_wr[i] & (lane_waddr[i] != '0) & ~kill[i];

        assign byp = {b_sel_mem[i], bundle_go & b_valid[i], rf_we[i],
                      lane_waddr[i], rf_wdata[i*XLEN +: XLEN]};
        assign wb_to_by_bus[i*BYP_W +: BYP_W] = byp;
    end

`ifdef WB_DEBUG_TRACE_EN
    localparam int CNT_W = $clog2(DBG_FIFO_DEPTH) + 1;

    logic [LANES*XLEN-1:0] b_pc;
    logic [CNT_W-1:0]      free_cnt;
    logic [LANES-1:0]      push_vld;
    trace_entry_t          push_data [LANES];
    trace_entry_t          head;
    logic                  head_vld;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            b_pc <= '0;
        end else if (accept) begin
            b_pc <= lane_pc;
        end
    end

    // Room for a whole bundle is required before it may retire.
    assign wb_ready_go = (32'(free_cnt) >= LANES);
    assign push_vld    = {LANES{bundle_go}} & b_valid;

    for (genvar i = 0; i < LANES; i++) begin : g_push
        assign push_data[i] = {b_pc[i*XLEN +: XLEN], rf_we[i], lane_waddr[i],
                               rf_wdata[i*XLEN +: XLEN]};
    end

    wb_trace_fifo #(
        .LANES (LANES),
        .DEPTH (DBG_FIFO_DEPTH)
    ) u_trace_fifo (
        .clk       (clk),
        .reset     (reset),
        .push_vld  (push_vld),
        .push_data (push_data),
        .head      (head),
        .head_vld  (head_vld),
        .free_cnt  (free_cnt)
    );

    assign debug_wb_pc       = head_vld ? head.pc    : '0;
    assign debug_wb_rf_wen   = {4{head_vld & head.we}};
    assign debug_wb_rf_wnum  = head_vld ? head.waddr : '0;
    assign debug_wb_rf_wdata = head_vld ? head.wdata : '0;
`else
    logic unused_pc;

    assign unused_pc         = ^lane_pc;
    assign wb_ready_go       = 1'b1;
    assign debug_wb_pc       = '0;
    assign debug_wb_rf_wen   = '0;
    assign debug_wb_rf_wnum  = '0;
    assign debug_wb_rf_wdata = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_wb_stage_mlane.sv
// ============================================================================
//  tb_wb_stage_mlane : directed self-checking bench for wb_stage_mlane
//                      (2 lanes, 32-bit, trace FIFO depth 4 when enabled).
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_wb_stage_mlane;

`ifdef WB_DEBUG_TRACE_EN
    localparam bit TR = 1'b1;
`else
    localparam bit TR = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        mem_to_wb_valid;
    logic        wb_allow_in;
    logic [1:0]  lane_valid;
    logic [63:0] lane_pc;
    logic [1:0]  lane_rf_wen;
    logic [9:0]  lane_rf_waddr;
    logic [1:0]  lane_sel_mem;
    logic [7:0]  lane_mem_bsel;
    logic [1:0]  lane_mem_unsigned;
    logic [63:0] lane_mem_rdata;
    logic [63:0] lane_alu_result;
    logic [1:0]  rf_we;
    logic [9:0]  rf_waddr;
    logic [63:0] rf_wdata;
    logic [79:0] wb_to_by_bus;
    logic [31:0] debug_wb_pc;
    logic [3:0]  debug_wb_rf_wen;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;

    int checks   = 0;
    int failures = 0;

    wb_stage_mlane #(
        .LANES          (2),
        .XLEN           (32),
        .RADDR_W        (5),
        .DBG_FIFO_DEPTH (4)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .mem_to_wb_valid   (mem_to_wb_valid),
        .wb_allow_in       (wb_allow_in),
        .lane_valid        (lane_valid),
        .lane_pc           (lane_pc),
        .lane_rf_wen       (lane_rf_wen),
        .lane_rf_waddr     (lane_rf_waddr),
        .lane_sel_mem      (lane_sel_mem),
        .lane_mem_bsel     (lane_mem_bsel),
        .lane_mem_unsigned (lane_mem_unsigned),
        .lane_mem_rdata    (lane_mem_rdata),
        .lane_alu_result   (lane_alu_result),
        .rf_we             (rf_we),
        .rf_waddr          (rf_waddr),
        .rf_wdata          (rf_wdata),
        .wb_to_by_bus      (wb_to_by_bus),
        .debug_wb_pc       (debug_wb_pc),
        .debug_wb_rf_wen   (debug_wb_rf_wen),
        .debug_wb_rf_wnum  (debug_wb_rf_wnum),
        .debug_wb_rf_wdata (debug_wb_rf_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic clear_lanes();
        lane_valid        = '0;
        lane_pc           = '0;
        lane_rf_wen       = '0;
        lane_rf_waddr     = '0;
        lane_sel_mem      = '0;
        lane_mem_bsel     = '0;
        lane_mem_unsigned = '0;
        lane_mem_rdata    = '0;
        lane_alu_result   = '0;
    endtask

    task automatic set_lane(input int i, input logic v, input logic [31:0] pc,
                            input logic wen, input logic [4:0] rd, input logic sm,
                            input logic [3:0] bs, input logic un,
                            input logic [31:0] rdata, input logic [31:0] alu);
        lane_valid[i]            = v;
        lane_pc[i*32 +: 32]      = pc;
        lane_rf_wen[i]           = wen;
        lane_rf_waddr[i*5 +: 5]  = rd;
        lane_sel_mem[i]          = sm;
        lane_mem_bsel[i*4 +: 4]  = bs;
        lane_mem_unsigned[i]     = un;
        lane_mem_rdata[i*32 +: 32]  = rdata;
        lane_alu_result[i*32 +: 32] = alu;
    endtask

    task automatic alu_bundle(input logic [31:0] pc, input logic [4:0] rd0, input logic [4:0] rd1);
        clear_lanes();
        set_lane(0, 1'b1, pc,        1'b1, rd0, 1'b0, 4'b0000, 1'b0, 32'h0, 32'h100 + 32'(rd0));
        set_lane(1, 1'b1, pc + 32'h4, 1'b1, rd1, 1'b0, 4'b0000, 1'b0, 32'h0, 32'h100 + 32'(rd1));
        mem_to_wb_valid = 1'b1;
    endtask

    initial begin
        reset = 1'b1;
        mem_to_wb_valid = 1'b0;
        clear_lanes();
        #2;
        check("rst_allow", wb_allow_in, 1'b1);
        check("rst_we", rf_we, 2'b00);
        check("rst_byp", wb_to_by_bus, 80'h0);
        check("rst_dbg_wen", debug_wb_rf_wen, 4'h0);
        check("rst_dbg_pc", debug_wb_pc, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(2);

        // Byte load from byte lane 2, signed and unsigned.
        clear_lanes();
        set_lane(0, 1'b1, 32'h100, 1'b1, 5'd3, 1'b1, 4'b0100, 1'b0, 32'h1280_3456, 32'h0);
        set_lane(1, 1'b1, 32'h104, 1'b1, 5'd4, 1'b1, 4'b0100, 1'b1, 32'h1280_3456, 32'h0);
        mem_to_wb_valid = 1'b1;
        tick();
        mem_to_wb_valid = 1'b0;
        mid();
        check("t1_we", rf_we, 2'b11);
        check("t1_waddr", rf_waddr, {5'd4, 5'd3});
        check("t1_sx", rf_wdata[31:0], 32'hFFFF_FF80);
        check("t1_zx", rf_wdata[63:32], 32'h0000_0080);
        check("t1_byp0", wb_to_by_bus[39:0], {1'b1, 1'b1, 1'b1, 5'd3, 32'hFFFF_FF80});

        // Upper halfword signed, and an illegal byte select.
        tick();
        clear_lanes();
        set_lane(0, 1'b1, 32'h180, 1'b1, 5'd6, 1'b1, 4'b1100, 1'b0, 32'h8001_0000, 32'h0);
        set_lane(1, 1'b1, 32'h184, 1'b1, 5'd7, 1'b1, 4'b0110, 1'b0, 32'h8001_0000, 32'h0);
        mem_to_wb_valid = 1'b1;
        tick();
        mem_to_wb_valid = 1'b0;
        mid();
        check("t2_half", rf_wdata[31:0], 32'hFFFF_8001);
        check("t2_bad_bsel", rf_wdata[63:32], 32'h0);
        check("t2_byp1", wb_to_by_bus[79:40], {1'b1, 1'b1, 1'b1, 5'd7, 32'h0});
        idle(4);

        // Same destination in both lanes: the higher lane wins.
        clear_lanes();
        set_lane(0, 1'b1, 32'h200, 1'b1, 5'd5, 1'b0, 4'b0000, 1'b0, 32'h0, 32'h11);
        set_lane(1, 1'b1, 32'h204, 1'b1, 5'd5, 1'b0, 4'b0000, 1'b0, 32'h0, 32'h22);
        mem_to_wb_valid = 1'b1;
        tick();
        mem_to_wb_valid = 1'b0;
        mid();
        check("t3_we", rf_we, 2'b10);
        check("t3_d1", rf_wdata[63:32], 32'h22);
        check("t3_byp0_wen", wb_to_by_bus[37], 1'b0);
        mid();
        check("t3_tr0_pc", debug_wb_pc, TR ? 32'h200 : 32'h0);
        check("t3_tr0_wen", debug_wb_rf_wen, 4'h0);
        check("t3_tr0_wnum", debug_wb_rf_wnum, TR ? 5'd5 : 5'd0);
        mid();
        check("t3_tr1_wen", debug_wb_rf_wen, TR ? 4'hF : 4'h0);
        check("t3_tr1_data", debug_wb_rf_wdata, TR ? 32'h22 : 32'h0);
        mid();
        check("t3_tr_empty", debug_wb_pc, 32'h0);

        // Write to r0 is suppressed with zero data; invalid lane 1 does nothing.
        tick();
        clear_lanes();
        set_lane(0, 1'b1, 32'h300, 1'b1, 5'd0, 1'b0, 4'b0000, 1'b0, 32'h0, 32'hDEAD);
        set_lane(1, 1'b0, 32'h304, 1'b1, 5'd9, 1'b0, 4'b0000, 1'b0, 32'h0, 32'hBEEF);
        mem_to_wb_valid = 1'b1;
        tick();
        mem_to_wb_valid = 1'b0;
        mid();
        check("t4_we", rf_we, 2'b00);
        check("t4_d0", rf_wdata[31:0], 32'h0);
        check("t4_byp1_valid", wb_to_by_bus[78], 1'b0);
        mid();
        check("t4_tr_pc", debug_wb_pc, TR ? 32'h300 : 32'h0);
        check("t4_tr_wen", debug_wb_rf_wen, 4'h0);
        check("t4_tr_wnum", debug_wb_rf_wnum, 5'd0);
        check("t4_tr_data", debug_wb_rf_wdata, 32'h0);
        mid();
        check("t4_tr_one_entry", debug_wb_pc, 32'h0);
        idle(6);

        // Three back-to-back bundles against a depth-4 trace FIFO.
        alu_bundle(32'h400, 5'd1, 5'd2);
        mid();
        check("t5_c0_allow", wb_allow_in, 1'b1);
        tick();
        alu_bundle(32'h410, 5'd3, 5'd4);
        mid();
        check("t5_c1_allow", wb_allow_in, 1'b1);
        check("t5_c1_we", rf_we, 2'b11);
        check("t5_c1_waddr", rf_waddr, {5'd2, 5'd1});
        tick();
        alu_bundle(32'h420, 5'd5, 5'd6);
        mid();
        check("t5_c2_allow", wb_allow_in, 1'b1);
        check("t5_c2_we", rf_we, 2'b11);
        check("t5_c2_waddr", rf_waddr, {5'd4, 5'd3});
        tick();
        mem_to_wb_valid = 1'b0;
        mid();
        check("t5_c3_allow", wb_allow_in, TR ? 1'b0 : 1'b1);
        check("t5_c3_we", rf_we, TR ? 2'b00 : 2'b11);
        check("t5_c3_waddr", rf_waddr, {5'd6, 5'd5});
        tick();
        mid();
        check("t5_c4_allow", wb_allow_in, 1'b1);
        check("t5_c4_we", rf_we, TR ? 2'b11 : 2'b00);
        check("t5_c4_waddr", rf_waddr, {5'd6, 5'd5});
        tick();
        mid();
        check("t5_c5_we", rf_we, 2'b00);
        idle(8);

        // Asynchronous reset while stalled with three trace entries queued.
        alu_bundle(32'h500, 5'd1, 5'd2);
        tick();
        alu_bundle(32'h510, 5'd3, 5'd4);
        tick();
        alu_bundle(32'h520, 5'd5, 5'd6);
        tick();
        mem_to_wb_valid = 1'b0;
        mid();
        check("t6_pre_allow", wb_allow_in, TR ? 1'b0 : 1'b1);
        check("t6_pre_dbg_wen", debug_wb_rf_wen, TR ? 4'hF : 4'h0);
        check("t6_pre_dbg_wnum", debug_wb_rf_wnum, TR ? 5'd2 : 5'd0);
        #1;
        reset = 1'b1;
        #1;
        check("t6_dbg_wen", debug_wb_rf_wen, 4'h0);
        check("t6_dbg_pc", debug_wb_pc, 32'h0);
        check("t6_allow", wb_allow_in, 1'b1);
        check("t6_we", rf_we, 2'b00);
        check("t6_byp", wb_to_by_bus, 80'h0);
        tick();
        reset = 1'b0;
        idle(2);
        mid();
        check("t6_post_we", rf_we, 2'b00);
        check("t6_post_dbg_wen", debug_wb_rf_wen, 4'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
